// File: rtl/cas_player.sv
// Cassette playback engine: fetches CAS image bytes over a req/ack read port and
// serialises them MSB-first as a Level II 500-baud pulse stream, gated by the motor bit.
module cas_player #(
  parameter int unsigned CELL_CYC  = 84000,
  parameter int unsigned DATA_OFS  = 42000,
  parameter int unsigned PULSE_CYC = 5250
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        start,
  input  logic        stop,
  input  logic [15:0] cas_len,
  input  logic        motor,
  output logic        rd_req,
  output logic [15:0] rd_addr,
  input  logic [7:0]  rd_data,
  input  logic        rd_ack,
  output logic        cas_bit,
  output logic        busy,
  output logic        done
);

  localparam int CYC_W = $clog2(CELL_CYC);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_PLAY,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [15:0]      len_q, len_d;
  logic [15:0]      addr_q, addr_d;
  logic [7:0]       shreg_q, shreg_d;
  logic [2:0]       bitcnt_q, bitcnt_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic             done_q, done_d;
  logic             cas_bit_q, cas_bit_d;

  logic [31:0] cyc_ext;
  logic [15:0] addr_inc;
  logic        cell_end;
  logic        clock_pulse;
  logic        data_pulse;

  // Pulse windows are evaluated in 32-bit space so DATA_OFS+PULSE_CYC may equal CELL_CYC.
  assign cyc_ext     = 32'(cyc_q);
  assign addr_inc    = addr_q + 16'd1;
  assign cell_end    = (cyc_ext == CELL_CYC - 32'd1);
  assign clock_pulse = (cyc_ext < PULSE_CYC);
  assign data_pulse  = shreg_q[7] && (cyc_ext >= DATA_OFS) &&
                       (cyc_ext < DATA_OFS + PULSE_CYC);

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    addr_d    = addr_q;
    shreg_d   = shreg_q;
    bitcnt_d  = bitcnt_q;
    cyc_d     = cyc_q;
    done_d    = done_q;
    cas_bit_d = 1'b0;

    if (stop) begin
      state_d = S_IDLE;
      done_d  = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            if (cas_len == 16'd0) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end else begin
              len_d   = cas_len;
              addr_d  = 16'd0;
              done_d  = 1'b0;
              state_d = S_FETCH;
            end
          end
        end

        S_FETCH: begin
          if (rd_ack) begin
            shreg_d  = rd_data;
            bitcnt_d = 3'd7;
            cyc_d    = '0;
            state_d  = S_PLAY;
          end
        end

        // With the motor off everything holds and the output stays low.
        S_PLAY: begin
          if (motor) begin
            cas_bit_d = clock_pulse || data_pulse;
            if (cell_end) begin
              if (bitcnt_q != 3'd0) begin
                shreg_d  = {shreg_q[6:0], 1'b0};
                bitcnt_d = bitcnt_q - 3'd1;
                cyc_d    = '0;
              end else begin
                addr_d = addr_inc;
                if (addr_inc == len_q) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
                end else begin
                  state_d = S_FETCH;
                end
              end
            end else begin
              cyc_d = cyc_q + CYC_W'(1);
            end
          end
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      len_q     <= '0;
      addr_q    <= '0;
      shreg_q   <= '0;
      bitcnt_q  <= '0;
      cyc_q     <= '0;
      done_q    <= 1'b0;
      cas_bit_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      addr_q    <= addr_d;
      shreg_q   <= shreg_d;
      bitcnt_q  <= bitcnt_d;
      cyc_q     <= cyc_d;
      done_q    <= done_d;
      cas_bit_q <= cas_bit_d;
    end
  end

  assign rd_req  = (state_q == S_FETCH);
  assign rd_addr = addr_q;
  assign busy    = (state_q == S_FETCH) || (state_q == S_PLAY);
  assign done    = done_q;
  assign cas_bit = cas_bit_q;

endmodule

// File: tb/tb_cas_player.sv
// Bench for cas_player: timeline-level model checked every cycle, plus directed
// scenarios with hand-computed pulse positions, cycle counts and addresses.
module tb_cas_player;

  localparam int CELL     = 20;
  localparam int DOFS     = 10;
  localparam int PULSE    = 2;
  localparam int BYTE_CYC = 8 * CELL;
  localparam int PH_IDLE  = 0;
  localparam int PH_FETCH = 1;
  localparam int PH_PLAY  = 2;
  localparam int PH_DONE  = 3;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        start   = 1'b0;
  logic        stop    = 1'b0;
  logic        motor   = 1'b0;
  logic        rd_ack  = 1'b0;
  logic [15:0] cas_len = '0;
  logic [7:0]  rd_data = '0;
  logic        rd_req, cas_bit, busy, done;
  logic [15:0] rd_addr;

  int checks = 0;
  int errors = 0;

  cas_player #(.CELL_CYC(CELL), .DATA_OFS(DOFS), .PULSE_CYC(PULSE)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .start(start), .stop(stop),
    .cas_len(cas_len), .motor(motor), .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_ack(rd_ack), .cas_bit(cas_bit), .busy(busy), .done(done)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Model: playback is a single timeline m_t of motor-on cycles within the current byte.
  int          m_phase = PH_IDLE;
  int          m_t = 0;
  logic [15:0] m_len = '0;
  logic [15:0] m_idx = '0;
  logic [7:0]  m_byte = '0;
  logic        m_cas = 1'b0;
  logic        m_done = 1'b0;
  int          ecnt = 0;
  int          m_ack_edge = 0;

  always @(posedge clk_sys or negedge reset_n) begin
    int  off;
    logic nxt_cas;
    if (!reset_n) begin
      m_phase = PH_IDLE; m_t = 0; m_len = '0; m_idx = '0;
      m_byte = '0; m_cas = 1'b0; m_done = 1'b0;
    end else begin
      ecnt++;
      nxt_cas = 1'b0;
      if (m_phase == PH_PLAY && motor) begin
        off = m_t % CELL;
        nxt_cas = (off < PULSE) ||
                  (m_byte[7 - m_t / CELL] && off >= DOFS && off < DOFS + PULSE);
      end
      if (stop) begin
        m_phase = PH_IDLE;
        m_done  = 1'b0;
        nxt_cas = 1'b0;
      end else if (m_phase == PH_IDLE || m_phase == PH_DONE) begin
        if (start) begin
          if (cas_len == 16'd0) begin
            m_phase = PH_DONE; m_done = 1'b1;
          end else begin
            m_len = cas_len; m_idx = '0; m_done = 1'b0; m_phase = PH_FETCH;
          end
        end
      end else if (m_phase == PH_FETCH) begin
        if (rd_ack) begin
          m_byte = rd_data; m_t = 0; m_phase = PH_PLAY; m_ack_edge = ecnt;
        end
      end else if (motor) begin
        if (m_t == BYTE_CYC - 1) begin
          m_idx = m_idx + 16'd1;
          if (m_idx == m_len) begin
            m_phase = PH_DONE; m_done = 1'b1;
          end else begin
            m_phase = PH_FETCH;
          end
        end else begin
          m_t++;
        end
      end
      m_cas = nxt_cas;
    end
  end

  bit   chk_en = 1'b0;
  logic prev_req = 1'b0;
  int   play_cnt = 0;
  int   cas_ones = 0;
  int   req_rises = 0;
  logic hist [0:8191];

  always @(negedge clk_sys) begin
    if (chk_en) begin
      checkOutput("rd_req", rd_req, m_phase == PH_FETCH);
      checkOutput("rd_addr", rd_addr, m_idx);
      checkOutput("cas_bit", cas_bit, m_cas);
      checkOutput("busy", busy, m_phase == PH_FETCH || m_phase == PH_PLAY);
      checkOutput("done", done, m_done);
    end
    if (ecnt < 8192) hist[ecnt] = cas_bit;
    if (busy && !rd_req) play_cnt++;
    if (cas_bit) cas_ones++;
    if (rd_req && !prev_req) req_rises++;
    prev_req = rd_req;
  end

  task automatic tick();
    @(negedge clk_sys);
  endtask

  task automatic clearCounters();
    play_cnt = 0; cas_ones = 0; req_rises = 0;
  endtask

  task automatic applyStimulus(input logic s_start, input logic s_stop,
                               input logic [15:0] len, input logic mot);
    start = s_start; stop = s_stop; cas_len = len; motor = mot;
    tick();
    start = 1'b0; stop = 1'b0;
  endtask

  task automatic serveRead(input int latency, input logic [7:0] data, input int exp_addr);
    int guard = 0;
    while (!rd_req && guard < 200) begin tick(); guard++; end
    if (!rd_req) begin
      checkOutput("read_timeout", 0, 1);
      return;
    end
    repeat (latency - 1) tick();
    checkOutput("rd_addr_at_ack", rd_addr, exp_addr);
    rd_ack = 1'b1; rd_data = data;
    tick();
    rd_ack = 1'b0; rd_data = '0;
  endtask

  task automatic waitDone(input int limit);
    int guard = 0;
    while (!done && guard < limit) begin tick(); guard++; end
    checkOutput("done_reached", done, 1);
  endtask

  task automatic waitEdge(input int target);
    int guard = 0;
    while (ecnt < target && guard < 1000) begin tick(); guard++; end
    checkOutput("edge_reached", ecnt, target);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int m;
    int ones;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    chk_en = 1'b1;

    $display("[TB] reset values");
    checkOutput("rst_rd_req", rd_req, 0);
    checkOutput("rst_rd_addr", rd_addr, 0);
    checkOutput("rst_cas_bit", cas_bit, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);

    // 0xA5 = 1,0,1,0,0,1,0,1: data pulses in cells 0, 2, 5 and 7 -> 8*2 + 4*2 = 24 high cycles.
    $display("[TB] single byte");
    clearCounters();
    applyStimulus(1'b1, 1'b0, 16'd1, 1'b1);
    serveRead(3, 8'hA5, 0);
    m = m_ack_edge;
    waitDone(400);
    checkOutput("single_busy_end", busy, 0);
    checkOutput("single_play_cycles", play_cnt, 160);
    checkOutput("single_high_cycles", cas_ones, 24);
    checkOutput("single_requests", req_rises, 1);
    checkOutput("single_cell0_clock", hist[m + 1], 1);
    checkOutput("single_cell0_data", hist[m + 11], 1);
    checkOutput("single_cell1_data", hist[m + 31], 0);
    checkOutput("single_cell2_data", hist[m + 51], 1);
    checkOutput("single_after_done", hist[m + 160], 0);

    $display("[TB] multi byte");
    clearCounters();
    applyStimulus(1'b1, 1'b0, 16'd3, 1'b1);
    serveRead(1, 8'h3C, 0);
    repeat (20) tick();
    rd_ack = 1'b1; rd_data = 8'hFF;
    tick();
    rd_ack = 1'b0; rd_data = '0;
    serveRead(7, 8'h81, 1);
    serveRead(4, 8'hE7, 2);
    waitDone(1000);
    checkOutput("multi_play_cycles", play_cnt, 480);
    checkOutput("multi_requests", req_rises, 3);
    checkOutput("multi_final_addr", rd_addr, 3);
    checkOutput("multi_busy_end", busy, 0);

    $display("[TB] stop");
    clearCounters();
    applyStimulus(1'b1, 1'b0, 16'd2, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b1, 16'd2, 1'b1);
    checkOutput("stop_rd_req", rd_req, 0);
    checkOutput("stop_busy", busy, 0);
    rd_ack = 1'b1; rd_data = 8'h55;
    tick();
    rd_ack = 1'b0; rd_data = '0;
    repeat (5) tick();
    checkOutput("late_ack_busy", busy, 0);
    checkOutput("late_ack_rd_req", rd_req, 0);
    checkOutput("late_ack_done", done, 0);
    applyStimulus(1'b1, 1'b1, 16'd4, 1'b1);
    repeat (3) tick();
    checkOutput("start_stop_busy", busy, 0);
    checkOutput("start_stop_rd_req", rd_req, 0);
    checkOutput("stop_requests", req_rises, 1);

    $display("[TB] zero length");
    clearCounters();
    applyStimulus(1'b1, 1'b0, 16'd0, 1'b1);
    checkOutput("zero_done", done, 1);
    checkOutput("zero_busy", busy, 0);
    repeat (3) tick();
    checkOutput("zero_requests", req_rises, 0);

    // Motor off for 30 edges from cyc=5 of cell 3; cell 4 clock pulse shifts from m+81 to m+111.
    $display("[TB] motor gating");
    clearCounters();
    applyStimulus(1'b1, 1'b0, 16'd1, 1'b1);
    serveRead(2, 8'hA5, 0);
    m = m_ack_edge;
    waitEdge(m + 65);
    motor = 1'b0;
    repeat (30) tick();
    motor = 1'b1;
    waitDone(500);
    ones = 0;
    for (int i = 66; i <= 96; i++) if (hist[m + i] === 1'b1) ones++;
    checkOutput("gate_quiet", ones, 0);
    checkOutput("gate_play_cycles", play_cnt, 190);
    checkOutput("gate_high_cycles", cas_ones, 24);
    checkOutput("gate_cell4_pre", hist[m + 110], 0);
    checkOutput("gate_cell4_clock", hist[m + 111], 1);

    $display("[TB] reset mid-play");
    clearCounters();
    applyStimulus(1'b1, 1'b0, 16'd2, 1'b1);
    serveRead(2, 8'h80, 0);
    serveRead(2, 8'hC3, 1);
    m = m_ack_edge;
    waitEdge(m + 1);
    checkOutput("pre_rst_cas_bit", cas_bit, 1);
    checkOutput("pre_rst_rd_addr", rd_addr, 1);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("async_rd_req", rd_req, 0);
    checkOutput("async_rd_addr", rd_addr, 0);
    checkOutput("async_cas_bit", cas_bit, 0);
    checkOutput("async_busy", busy, 0);
    checkOutput("async_done", done, 0);
    tick();
    reset_n = 1'b1;
    repeat (2) tick();
    checkOutput("post_rst_busy", busy, 0);
    checkOutput("post_rst_rd_req", rd_req, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cas_player.md
# cas_player

Cassette playback engine for the TRS-80 core. It fetches bytes of a downloaded CAS image from core RAM through a request/acknowledge read port and serialises them MSB-first into the Level II 500-baud pulse stream. The stream drives the machine's cassette input comparator. It sits between the cassette download region, which the download mux fills from `ioctl` index 1, and the `trs80` cassette-in path, and it is gated by the CPU-controlled cassette motor bit.

## Interface
Parameters:
- `CELL_CYC`, default 84000: `clk_sys` cycles per bit cell (2 ms at 42 MHz).
- `DATA_OFS`, default 42000: cycle offset of the data pulse within a cell.
- `PULSE_CYC`, default 5250: pulse width in cycles (125 µs).
- Legality: `PULSE_CYC` ≤ `DATA_OFS` and `DATA_OFS + PULSE_CYC` ≤ `CELL_CYC`.

Ports:
- `clk_sys` in 1: system clock (42 MHz).
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse that begins playback from image offset 0.
- `stop` in 1: one-cycle pulse that aborts playback.
- `cas_len` in 16: image length in bytes, sampled at `start`.
- `motor` in 1: cassette motor on; playback advances only while high.
- `rd_req` out 1: read request, held high until acknowledged.
- `rd_addr` out 16: byte offset within the cassette region.
- `rd_data` in 8: read data, valid in the cycle `rd_ack` is high.
- `rd_ack` in 1: one-cycle read acknowledge; latency is arbitrary.
- `cas_bit` out 1: pulse stream to the cassette input.
- `busy` out 1: high in the FETCH and PLAY states.
- `done` out 1: sticky end-of-image flag.

## Operation
- States: IDLE, FETCH, PLAY, DONE.
- Registers:
  - `len`: 16 bits, latched `cas_len`.
  - `addr`: 16 bits.
  - `shreg`: 8 bits.
  - `bitcnt`: 3 bits.
  - `cyc`: $clog2(`CELL_CYC`) bits.
- IDLE or DONE with `start`=1 and `stop`=0:
  - If `cas_len` is 0, go to DONE with `done`=1; no read is issued.
  - Otherwise latch `len`, set `addr`=0, clear `done`, go to FETCH.
- `start` is ignored in FETCH and PLAY.
- FETCH: `rd_req`=1 and `rd_addr`=`addr`. On `rd_ack`, set `shreg`=`rd_data`, `bitcnt`=7, `cyc`=0, and go to PLAY.
- `rd_ack` outside FETCH is ignored.
- PLAY, `motor`=1: `cyc` increments each cycle. At `cyc`=`CELL_CYC`-1:
  - If `bitcnt`≠0: shift `shreg` left by 1, decrement `bitcnt`, set `cyc`=0.
  - If `bitcnt`=0: `addr`+1 (16-bit). If `addr`+1 = `len`, go to DONE and set `done`=1; otherwise go to FETCH.
- PLAY, `motor`=0: `cyc`, `shreg` and `bitcnt` are frozen and `cas_bit` is forced to 0. Playback resumes at the frozen `cyc`.
- Motor state does not affect FETCH. The read completes regardless.
- `cas_bit` (registered) is 1 only in PLAY with `motor`=1, when either:
  - `cyc` < `PULSE_CYC` (clock pulse), or
  - `shreg[7]`=1 and `DATA_OFS` ≤ `cyc` < `DATA_OFS+PULSE_CYC` (data pulse).
- In every other case `cas_bit` is 0.
- `stop`, in any state: go to IDLE, drop `rd_req`, set `cas_bit`=0, clear `done`.
- `stop` wins over a simultaneous `start` or `rd_ack`.
- A pending read abandoned by `stop` must be tolerated; the late `rd_ack` is ignored.
- The inter-byte gap equals the fetch latency plus 1 cycle. This gap is accepted.

## Timing
- Reset values:
  - State IDLE.
  - `rd_req`=0, `rd_addr`=0, `cas_bit`=0, `busy`=0, `done`=0.
  - All internal counters 0.
- `start` sampled at edge N: `rd_req`=1 and `busy`=1 after edge N.
- `rd_ack` sampled at edge M: `rd_req`=0 after M; the PLAY state has `cyc`=0 after M.
- `cas_bit` lags `cyc` by one register stage: the clock pulse is high from after edge M+1 through `PULSE_CYC` cycles.
- Bit cell length: exactly `CELL_CYC` cycles while the motor is on.
- Reaching DONE: `done`=1 and `busy`=0 after the final cell's last edge. `cas_bit` is already 0 at that point.
- Asynchronous reset mid-operation: all outputs go to reset values immediately.

## Test plan
Sim parameters: `CELL_CYC`=20, `DATA_OFS`=10, `PULSE_CYC`=2.

- **Reset.** Assert `reset_n`=0 mid-PLAY -> all outputs 0 immediately; state is IDLE after release.
- **Single byte.** `cas_len`=1, `motor`=1, `start`; ack 3 cycles later with 0xA5 -> `rd_addr`=0 and 160 cycles of PLAY. `cas_bit` is high for 2 cycles at each cell start, and at offset 10 in cells 0, 2, 5 and 7 (data 1,0,1,0,0,1,0,1). Then `done`=1 and `busy`=0.
- **Multi-byte with variable latency.** `cas_len`=3, ack latencies 1, 7 and 4 -> reads at addresses 0, 1 and 2 in order, one request each, 480 PLAY cycles total, then `done`. A stray `rd_ack` during PLAY changes nothing.
- **Zero length.** `cas_len`=0, `start` -> `rd_req` never asserts; `done`=1 the next cycle.
- **Motor gating.** Drop `motor` at `cyc`=5 of cell 3 for 30 cycles -> `cas_bit`=0 throughout. The cell resumes at `cyc`=5, and the total PLAY duration is extended by exactly 30.
- **Stop.** `stop` during FETCH -> `rd_req` falls the next cycle; the late `rd_ack` is ignored; the block stays IDLE. `start` and `stop` in the same cycle from IDLE -> remains IDLE with no request.
